// File: rtl/bdpsk_demod.sv
// Binary differential PSK demodulator: one carrier period per symbol, correlated
// against a square-wave reference; a phase reversal between symbols decodes as 1.
module bdpsk_demod #(
    parameter logic [15:0] AMP_THRESH = 16'd2048
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sync,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    output logic       bit_valid,
    output logic       bit_out,
    output logic       low_amp,
    output logic       locked
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACQ   = 2'd1;
    localparam logic [1:0] TRACK = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [6:0]         cnt_q, cnt_d;
    logic signed [15:0] acc_q, acc_d;
    logic               prev_sign_q, prev_sign_d;
    logic               bit_valid_q, bit_valid_d;
    logic               bit_out_q, bit_out_d;
    logic               low_amp_q, low_amp_d;

    logic signed [8:0]  s9;
    logic signed [15:0] s16;
    logic signed [15:0] term;
    logic signed [15:0] acc_sum;
    logic [15:0]        mag;
    logic               sym_sign;
    logic               sym_low;

    // Offset-128 sample to signed; 9-bit wrap of the subtraction gives -128..127.
    assign s9       = $signed({1'b0, sample} - 9'd128);
    assign s16      = {{7{s9[8]}}, s9};
    assign term     = cnt_q[6] ? -s16 : s16;
    assign acc_sum  = acc_q + term;
    assign sym_sign = acc_sum[15];
    assign mag      = acc_sum[15] ? 16'(-acc_sum) : 16'(acc_sum);
    assign sym_low  = (mag < AMP_THRESH);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prev_sign_d = prev_sign_q;
        bit_valid_d = 1'b0;
        bit_out_d   = bit_out_q;
        low_amp_d   = low_amp_q;

        if (sync) begin
            // A coincident sample opens the new symbol as index 0 (always added).
            state_d = ACQ;
            if (sample_valid) begin
                acc_d = s16;
                cnt_d = 7'd1;
            end else begin
                acc_d = '0;
                cnt_d = '0;
            end
        end else if (sample_valid) begin
            if (state_q == IDLE) begin
                state_d = ACQ;
            end
            if (cnt_q == 7'd127) begin
                acc_d     = '0;
                cnt_d     = '0;
                low_amp_d = sym_low;
                if (state_q == TRACK) begin
                    bit_valid_d = 1'b1;
                    bit_out_d   = sym_sign ^ prev_sign_q;
                    prev_sign_d = sym_sign;
                end else if (!sym_low) begin
                    prev_sign_d = sym_sign;
                    state_d     = TRACK;
                end
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            prev_sign_q <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            low_amp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prev_sign_q <= prev_sign_d;
            bit_valid_q <= bit_valid_d;
            bit_out_q   <= bit_out_d;
            low_amp_q   <= low_amp_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_out_q;
    assign low_amp   = low_amp_q;
    assign locked    = (state_q == TRACK);

endmodule

// File: tb/tb_bdpsk_demod.sv
// Directed + randomized bench for bdpsk_demod against a symbol-level reference
// model (correlation sum over a whole 128-sample symbol, differential decode).
module tb_bdpsk_demod;

    typedef logic [7:0] sym_t [128];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sync = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'd128;
    logic       bit_valid, bit_out, low_amp, locked;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;

    // Reference model state
    bit m_locked = 1'b0;
    bit m_prev = 1'b0;
    bit m_bo = 1'b0;
    int m_pulses = 0;

    bdpsk_demod #(.AMP_THRESH(16'd2048)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sync(sync),
        .sample_valid(sample_valid),
        .sample(sample),
        .bit_valid(bit_valid),
        .bit_out(bit_out),
        .low_amp(low_amp),
        .locked(locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (bit_valid === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sym_final(input sym_t x);
        int f = 0;
        for (int i = 0; i < 128; i++) begin
            if (i < 64) f += int'(x[i]) - 128;
            else        f -= int'(x[i]) - 128;
        end
        return f;
    endfunction

    task automatic make_sine(output sym_t x, input real amp, input bit inv);
        int t;
        for (int i = 0; i < 128; i++) begin
            t = 128 + int'(amp * 63.5 * $sin(2.0 * 3.14159265358979 * i / 128.0));
            x[i] = inv ? 8'(255 - t) : 8'(t);
        end
    endtask

    task automatic make_square(output sym_t x, input bit inv);
        for (int i = 0; i < 128; i++) x[i] = ((i < 64) ^ inv) ? 8'd255 : 8'd0;
    endtask

    task automatic complete(input sym_t x);
        int  f;
        bit  sgn, low, pulse;
        #2;
        f     = sym_final(x);
        sgn   = (f < 0);
        low   = ((f < 0 ? -f : f) < 2048);
        pulse = m_locked;
        if (m_locked) begin
            m_bo = sgn ^ m_prev;
            m_prev = sgn;
            m_pulses++;
        end else if (!low) begin
            m_locked = 1'b1;
            m_prev = sgn;
        end
        chk("bit_valid", bit_valid, pulse);
        chk("bit_out", bit_out, m_bo);
        chk("low_amp", low_amp, low);
        chk("locked", locked, m_locked);
        chk("pulse_count", pulse_cnt, m_pulses);
    endtask

    // Drive x[lo..hi-1] with random idle gaps; a symbol ending at 127 is checked
    // one cycle after its last accepted sample.
    task automatic feed(input sym_t x, input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++) begin
            while ($urandom_range(99) < gap) begin
                sample_valid = 1'b0;
                sample = 8'($urandom);
                @(negedge clk);
            end
            sample_valid = 1'b1;
            sample = x[i];
            @(negedge clk);
        end
        sample_valid = 1'b0;
        if (hi == 128) complete(x);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_bit_valid", bit_valid, 1'b0);
        chk("rst_bit_out", bit_out, 1'b0);
        chk("rst_low_amp", low_amp, 1'b0);
        chk("rst_locked", locked, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_locked = 1'b0;
        m_prev = 1'b0;
        m_bo = 1'b0;
    endtask

    sym_t s0, spi, sq, sqi, sc, sr;

    initial begin
        make_sine(s0, 1.0, 1'b0);
        make_sine(spi, 1.0, 1'b1);
        make_square(sq, 1'b0);
        make_square(sqi, 1'b1);
        for (int i = 0; i < 128; i++) sc[i] = 8'd128;

        // Power-on reset
        repeat (2) @(negedge clk);
        do_reset();

        // Gap-free sine stream 0, 0, pi
        feed(s0, 0, 128, 0);
        feed(s0, 0, 128, 0);
        feed(spi, 0, 128, 0);

        // Full-scale square waves, alternating polarity
        chk("sq_final", 32'(sym_final(sq)), 32'(16320));
        feed(sq, 0, 128, 0);
        feed(sqi, 0, 128, 0);
        feed(sq, 0, 128, 0);
        feed(sqi, 0, 128, 0);

        // Zero-energy symbol, then a sine decoded against positive prev_sign
        feed(sc, 0, 128, 0);
        feed(s0, 0, 128, 0);

        // Same stream with ~50% sample_valid gaps after a fresh reset
        do_reset();
        feed(s0, 0, 128, 50);
        feed(s0, 0, 128, 50);
        feed(spi, 0, 128, 50);

        // Sync at index 50 of a tracking symbol
        feed(s0, 0, 50, 0);
        sync = 1'b1;
        sample_valid = 1'b1;
        sample = s0[0];
        @(negedge clk);
        sync = 1'b0;
        sample_valid = 1'b0;
        m_locked = 1'b0;
        chk("sync_locked", locked, 1'b0);
        feed(s0, 1, 128, 0);
        feed(spi, 0, 128, 0);

        // Reset while bit_valid is high, then reset at index 90
        feed(s0, 0, 128, 0);
        chk("pre_rst_pulse", bit_valid, 1'b1);
        do_reset();
        feed(spi, 0, 128, 0);
        feed(s0, 0, 90, 0);
        do_reset();
        feed(s0, 0, 128, 0);
        feed(spi, 0, 128, 0);

        // Randomized symbols: scaled sines of either phase, flat or noisy symbols
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(7))
                0: for (int i = 0; i < 128; i++) sr[i] = 8'($urandom);
                1: for (int i = 0; i < 128; i++) sr[i] = 8'($urandom_range(120, 136));
                default: make_sine(sr, $urandom_range(100) / 100.0, 1'($urandom));
            endcase
            feed(sr, 0, 128, $urandom_range(60));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
